segment_collision_checker: RTL and testbench
============================================

SEGMENT_COLLISION_CHECKER -- requirements
Module: segment_collision_checker

Interface
REQ-001 SHALL have parameter GRID_WIDTH_LOG2, default 4: grid x-coordinate width in bits.
REQ-002 SHALL have parameter GRID_HEIGHT_LOG2, default 4: grid y-coordinate width in bits.
REQ-003 SHALL have port clk, input, 1: the only clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports start_x/end_x, input, GRID_WIDTH_LOG2 each: segment x endpoints, both inclusive.
REQ-006 SHALL have ports start_y/end_y, input, GRID_HEIGHT_LOG2 each: segment y endpoints, both inclusive.
REQ-007 SHALL have ports req_valid (input, 1) and req_ready (output, 1): request handshake.
REQ-008 SHALL have ports resp_valid (output, 1), resp_ready (input, 1) and resp_collision (output, 1): result handshake; resp_collision=1 means some cell on the segment is occupied.
REQ-009 SHALL have grid-side ports grid_cell_x (output, GRID_WIDTH_LOG2) and grid_cell_y (output, GRID_HEIGHT_LOG2).
REQ-010 SHALL have grid-side ports grid_input_valid (output, 1), grid_ready_for_input (input, 1), grid_output_valid (input, 1) and grid_read_occupied (input, 1).
REQ-011 SHALL have grid-side ports grid_write_enable and grid_write_occupied (outputs, 1 each), both tied to 0.

Function
REQ-012 SHALL accept a request only in IDLE, on a cycle where req_valid && req_ready; endpoints are latched on that cycle.
REQ-013 SHALL implement states IDLE, ISSUE, WAIT and DONE.
- IDLE->ISSUE on request accept.
- ISSUE->WAIT on grid_input_valid && grid_ready_for_input.
- WAIT->ISSUE when grid_output_valid arrives, the cell is free and it is not the end cell.
- WAIT->DONE when grid_output_valid arrives and the cell is occupied or is the end cell.
- DONE->IDLE on resp_valid && resp_ready.
REQ-014 SHALL walk cells by integer Bresenham.
- Setup: dx=|ex-sx|, dy=-|ey-sy|, err=dx+dy.
- Per step: e2=2*err; if e2>=dy then err+=dy and x steps toward ex; if e2<=dx then err+=dx and y steps toward ey.
- Diagonal steps are therefore allowed.
REQ-015 SHALL hold err and e2 in signed registers of max(GRID_WIDTH_LOG2,GRID_HEIGHT_LOG2)+2 bits, with no overflow for any endpoint pair.
REQ-016 SHALL keep at most one grid query outstanding, and SHALL hold grid_cell_x/y and grid_input_valid stable in ISSUE until accepted.
REQ-017 SHALL terminate early on the first occupied cell, with resp_collision=1.
REQ-018 SHALL, when start equals end, query exactly that one cell.
REQ-019 SHALL in DONE hold resp_valid=1 and a stable resp_collision until resp_ready; back-pressure is unbounded.
REQ-020 SHALL ignore grid_output_valid in any state other than WAIT.
REQ-021 SHALL issue the next query on the cycle after the previous response; per-cell cost is 1 cycle plus the grid latency.

Reset
REQ-022 SHALL, on rst at any point including mid-walk, enter IDLE. Reset values: req_ready=1; resp_valid=0; resp_collision=0; grid_input_valid=0; grid_cell_x/y=0.
REQ-023 SHALL discard any grid response arriving after reset.

Configuration
REQ-024 SHALL support macro SEGMENT_CHECK_HIT_REPORT_EN.
- Defined: outputs resp_hit_x (GRID_WIDTH_LOG2) and resp_hit_y (GRID_HEIGHT_LOG2) give the first occupied cell, valid with resp_valid when resp_collision=1, otherwise 0; reset value 0.
- Undefined: those ports and their registers do not exist; all other behaviour is identical.

Structure
REQ-025 SHALL take its state enum typedef and the error-width constant function from the shared package segment_check_pkg.
REQ-026 SHALL contain one sub-module, bresenham_stepper: latch/init, step and at_end, with no handshake logic.

Verification
REQ-027 Empty 16x16 grid, segment (0,0)->(15,15) -> 16 queries along the diagonal, resp_collision=0.
REQ-028 Cell (5,2) occupied, segment (0,0)->(10,4) -> queries stop at (5,2), resp_collision=1, hit=(5,2) when REQ-024 is enabled.
REQ-029 Segment (7,3)->(7,3), cell free -> exactly 1 query, resp_collision=0; same segment with cell occupied -> resp_collision=1.
REQ-030 Segment (12,9)->(2,9) with grid_ready_for_input held low for 5 cycles -> address stable throughout, 11 queries in descending x.
REQ-031 resp_ready low for 10 cycles in DONE -> resp_valid and resp_collision held; req_ready=0 until the handshake completes.
REQ-032 rst asserted in WAIT, followed by a late grid_output_valid -> IDLE, response ignored, no resp_valid; next request completes correctly.

Source files
------------

// File: rtl/segment_check_pkg.sv
// Shared types and sizing helpers for the segment collision checker.
// Walk FSM state encoding and Bresenham error-register width.
package segment_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Two extra bits keep 2*err inside the signed range for any endpoints.
    function automatic int err_width(input int w, input int h);
        return ((w > h) ? w : h) + 2;
    endfunction

endpackage

// File: rtl/bresenham_stepper.sv
// Integer Bresenham cell walker: latches endpoints on init, advances on step.
// Reports at_end when the current cell equals the latched end cell.
module bresenham_stepper
    import segment_check_pkg::*;
#(
    parameter int GRID_WIDTH_LOG2  = 4,
    parameter int GRID_HEIGHT_LOG2 = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        init,
    input  logic                        step,
    input  logic [GRID_WIDTH_LOG2-1:0]  start_x,
    input  logic [GRID_HEIGHT_LOG2-1:0] start_y,
    input  logic [GRID_WIDTH_LOG2-1:0]  end_x,
    input  logic [GRID_HEIGHT_LOG2-1:0] end_y,
    output logic [GRID_WIDTH_LOG2-1:0]  x,
    output logic [GRID_HEIGHT_LOG2-1:0] y,
    output logic                        at_end
);

    localparam int W  = GRID_WIDTH_LOG2;
    localparam int H  = GRID_HEIGHT_LOG2;
    localparam int EW = err_width(W, H);

    logic [W-1:0]          end_xr;
    logic [H-1:0]          end_yr;
    logic                  dir_x;
    logic                  dir_y;
    logic signed [EW-1:0]  dx;
    logic signed [EW-1:0]  dy;
    logic signed [EW-1:0]  err;
    logic signed [EW-1:0]  e2;

    logic [W-1:0]          adx;
    logic [H-1:0]          ady;
    logic signed [EW-1:0]  init_dx;
    logic signed [EW-1:0]  init_dy;
    logic signed [EW-1:0]  init_err;

    logic [W-1:0]          x_n;
    logic [H-1:0]          y_n;
    logic signed [EW-1:0]  err_n;

    always_comb begin
        adx      = (end_x >= start_x) ? end_x - start_x : start_x - end_x;
        ady      = (end_y >= start_y) ? end_y - start_y : start_y - end_y;
        init_dx  = {{(EW-W){1'b0}}, adx};
        init_dy  = -{{(EW-H){1'b0}}, ady};
        init_err = init_dx + init_dy;
    end

    // Both axis decisions use e2 from before this step, so diagonals happen.
    always_comb begin
        x_n   = x;
        y_n   = y;
        err_n = err;
        if (e2 >= dy) begin
            err_n = err_n + dy;
            x_n   = dir_x ? x + 1'b1 : x - 1'b1;
        end
        if (e2 <= dx) begin
            err_n = err_n + dx;
            y_n   = dir_y ? y + 1'b1 : y - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x      <= '0;
            y      <= '0;
            end_xr <= '0;
            end_yr <= '0;
            dir_x  <= 1'b0;
            dir_y  <= 1'b0;
            dx     <= '0;
            dy     <= '0;
            err    <= '0;
            e2     <= '0;
        end else if (init) begin
            x      <= start_x;
            y      <= start_y;
            end_xr <= end_x;
            end_yr <= end_y;
            dir_x  <= (end_x >= start_x);
            dir_y  <= (end_y >= start_y);
            dx     <= init_dx;
            dy     <= init_dy;
            err    <= init_err;
            e2     <= init_err <<< 1;
        end else if (step) begin
            x      <= x_n;
            y      <= y_n;
            err    <= err_n;
            e2     <= err_n <<< 1;
        end
    end

    assign at_end = (x == end_xr) && (y == end_yr);

endmodule

// File: rtl/segment_collision_checker.sv
// Walks a grid segment one cell query at a time, stopping at the first hit.
// Optional SEGMENT_CHECK_HIT_REPORT_EN adds resp_hit_x/resp_hit_y outputs.
module segment_collision_checker
    import segment_check_pkg::*;
#(
    parameter int GRID_WIDTH_LOG2  = 4,
    parameter int GRID_HEIGHT_LOG2 = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [GRID_WIDTH_LOG2-1:0]  start_x,
    input  logic [GRID_HEIGHT_LOG2-1:0] start_y,
    input  logic [GRID_WIDTH_LOG2-1:0]  end_x,
    input  logic [GRID_HEIGHT_LOG2-1:0] end_y,
    input  logic                        req_valid,
    output logic                        req_ready,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic                        resp_collision,
`ifdef SEGMENT_CHECK_HIT_REPORT_EN
    output logic [GRID_WIDTH_LOG2-1:0]  resp_hit_x,
    output logic [GRID_HEIGHT_LOG2-1:0] resp_hit_y,
`endif
    output logic [GRID_WIDTH_LOG2-1:0]  grid_cell_x,
    output logic [GRID_HEIGHT_LOG2-1:0] grid_cell_y,
    output logic                        grid_input_valid,
    input  logic                        grid_ready_for_input,
    input  logic                        grid_output_valid,
    input  logic                        grid_read_occupied,
    output logic                        grid_write_enable,
    output logic                        grid_write_occupied
);

    state_t state;
    state_t state_n;
    logic   init;
    logic   step;
    logic   at_end;
    logic   accept;
    logic   hit;

    bresenham_stepper #(
        .GRID_WIDTH_LOG2 (GRID_WIDTH_LOG2),
        .GRID_HEIGHT_LOG2(GRID_HEIGHT_LOG2)
    ) u_stepper (
        .clk    (clk),
        .rst    (rst),
        .init   (init),
        .step   (step),
        .start_x(start_x),
        .start_y(start_y),
        .end_x  (end_x),
        .end_y  (end_y),
        .x      (grid_cell_x),
        .y      (grid_cell_y),
        .at_end (at_end)
    );

    assign accept = (state == IDLE) && req_valid;
    assign hit    = (state == WAIT) && grid_output_valid && grid_read_occupied;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        init    = 1'b0;
        step    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    init    = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (grid_ready_for_input) state_n = WAIT;
            end
            WAIT: begin
                if (grid_output_valid) begin
                    if (grid_read_occupied || at_end) begin
                        state_n = DONE;
                    end else begin
                        step    = 1'b1;
                        state_n = ISSUE;
                    end
                end
            end
            DONE: begin
                if (resp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)         resp_collision <= 1'b0;
        else if (accept) resp_collision <= 1'b0;
        else if (hit)    resp_collision <= 1'b1;
    end

`ifdef SEGMENT_CHECK_HIT_REPORT_EN
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            resp_hit_x <= '0;
            resp_hit_y <= '0;
        end else if (hit) begin
            resp_hit_x <= grid_cell_x;
            resp_hit_y <= grid_cell_y;
        end
    end
`endif

    assign req_ready           = (state == IDLE);
    assign resp_valid          = (state == DONE);
    assign grid_input_valid    = (state == ISSUE);
    assign grid_write_enable   = 1'b0;
    assign grid_write_occupied = 1'b0;

endmodule

// File: tb/tb_segment_collision_checker.sv
// Scoreboard bench for segment_collision_checker with a latency grid model.
// Define SEGMENT_CHECK_HIT_REPORT_EN to also check the hit coordinates.
module tb_segment_collision_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] start_x, start_y, end_x, end_y;
    logic       req_valid, req_ready;
    logic       resp_valid, resp_ready, resp_collision;
`ifdef SEGMENT_CHECK_HIT_REPORT_EN
    logic [3:0] resp_hit_x, resp_hit_y;
`endif
    logic [3:0] grid_cell_x, grid_cell_y;
    logic       grid_input_valid, grid_ready_for_input;
    logic       grid_output_valid, grid_read_occupied;
    logic       grid_write_enable, grid_write_occupied;

    always #5 clk = ~clk;

    segment_collision_checker #(
        .GRID_WIDTH_LOG2 (4),
        .GRID_HEIGHT_LOG2(4)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start_x             (start_x),
        .start_y             (start_y),
        .end_x               (end_x),
        .end_y               (end_y),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .resp_valid          (resp_valid),
        .resp_ready          (resp_ready),
        .resp_collision      (resp_collision),
`ifdef SEGMENT_CHECK_HIT_REPORT_EN
        .resp_hit_x          (resp_hit_x),
        .resp_hit_y          (resp_hit_y),
`endif
        .grid_cell_x         (grid_cell_x),
        .grid_cell_y         (grid_cell_y),
        .grid_input_valid    (grid_input_valid),
        .grid_ready_for_input(grid_ready_for_input),
        .grid_output_valid   (grid_output_valid),
        .grid_read_occupied  (grid_read_occupied),
        .grid_write_enable   (grid_write_enable),
        .grid_write_occupied (grid_write_occupied)
    );

    bit occ [16][16];
    int lat = 1;
    int n_cmp = 0;
    int n_bad = 0;
    int n_q = 0;
    int qx_q[$], qy_q[$], hx_q[$], hy_q[$];
    bit coll_q[$];
    int last_qx, last_qy;

    // Grid model: acts just after each falling edge so inputs are settled.
    int       lat_cnt = 0;
    int       pend_x, pend_y;
    bit       stalled = 0;
    int       hold_x, hold_y;
    always begin
        @(negedge clk);
        #1;
        grid_output_valid  = 1'b0;
        grid_read_occupied = 1'b0;
        if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                grid_output_valid  = 1'b1;
                grid_read_occupied = occ[pend_x][pend_y];
            end
        end
        if (grid_input_valid && stalled) begin
            n_cmp++;
            if (grid_cell_x !== hold_x[3:0] || grid_cell_y !== hold_y[3:0]) begin
                n_bad++;
                $display("FAIL stall_addr: got (%0d,%0d) want (%0d,%0d)",
                         grid_cell_x, grid_cell_y, hold_x, hold_y);
            end
        end
        if (grid_input_valid && grid_ready_for_input) begin
            n_q++;
            pend_x  = grid_cell_x;
            pend_y  = grid_cell_y;
            last_qx = pend_x;
            last_qy = pend_y;
            lat_cnt = lat;
            n_cmp++;
            if (qx_q.size() == 0) begin
                n_bad++;
                $display("FAIL query_extra: got (%0d,%0d) want none",
                         pend_x, pend_y);
            end else begin
                if (pend_x != qx_q[0] || pend_y != qy_q[0]) begin
                    n_bad++;
                    $display("FAIL query_cell: got (%0d,%0d) want (%0d,%0d)",
                             pend_x, pend_y, qx_q[0], qy_q[0]);
                end
                void'(qx_q.pop_front());
                void'(qy_q.pop_front());
            end
        end
        stalled = grid_input_valid && !grid_ready_for_input;
        hold_x  = grid_cell_x;
        hold_y  = grid_cell_y;
    end

    task automatic model_push(input int sx, input int sy, input int ex,
                              input int ey, output int cnt);
        int x, y, dx, dy, err, e2;
        bit c;
        x = sx; y = sy; c = 0; cnt = 0;
        dx = (ex > sx) ? ex - sx : sx - ex;
        dy = (ey > sy) ? sy - ey : ey - sy;
        err = dx + dy;
        while (1) begin
            qx_q.push_back(x);
            qy_q.push_back(y);
            cnt++;
            if (occ[x][y]) begin
                c = 1;
                break;
            end
            if (x == ex && y == ey) break;
            e2 = 2 * err;
            if (e2 >= dy) begin
                err += dy;
                x += (ex > sx) ? 1 : -1;
            end
            if (e2 <= dx) begin
                err += dx;
                y += (ey > sy) ? 1 : -1;
            end
        end
        coll_q.push_back(c);
        hx_q.push_back(c ? x : 0);
        hy_q.push_back(c ? y : 0);
    endtask

    task automatic send_req(input int sx, input int sy, input int ex, input int ey);
        @(negedge clk);
        start_x   = sx[3:0];
        start_y   = sy[3:0];
        end_x     = ex[3:0];
        end_y     = ey[3:0];
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output bit to);
        to = 1;
        for (int i = 0; i < 3000; i++) begin
            if (resp_valid) begin
                to = 0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic clear_grid();
        foreach (occ[i, j]) occ[i][j] = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_collision !== 1'b0 ||
            grid_input_valid !== 1'b0 || grid_cell_x !== 4'd0 || grid_cell_y !== 4'd0 ||
            grid_write_enable !== 1'b0 || grid_write_occupied !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got rr=%b rv=%b rc=%b gv=%b cell=(%0d,%0d) want 1 0 0 0 (0,0)",
                     req_ready, resp_valid, resp_collision, grid_input_valid,
                     grid_cell_x, grid_cell_y);
        end
`ifdef SEGMENT_CHECK_HIT_REPORT_EN
        n_cmp++;
        if (resp_hit_x !== 4'd0 || resp_hit_y !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_hit: got (%0d,%0d) want (0,0)", resp_hit_x, resp_hit_y);
        end
`endif
    endtask

    // Runs one segment, checking the response and the number of queries.
    task automatic test_segment(input string name, input int sx, input int sy,
                                input int ex, input int ey, input int want_q);
        int  cnt, q0;
        bit  to, ec;
        int  ehx, ehy;
        model_push(sx, sy, ex, ey, cnt);
        q0 = n_q;
        send_req(sx, sy, ex, ey);
        wait_resp(to);
        ec  = coll_q.pop_front();
        ehx = hx_q.pop_front();
        ehy = hy_q.pop_front();
        n_cmp++;
        if (to) begin
            n_bad++;
            $display("FAIL %s_timeout: got no resp_valid want resp_valid", name);
        end else if (resp_collision !== ec) begin
            n_bad++;
            $display("FAIL %s_collision: got %b want %b", name, resp_collision, ec);
        end
`ifdef SEGMENT_CHECK_HIT_REPORT_EN
        n_cmp++;
        if (resp_hit_x !== ehx[3:0] || resp_hit_y !== ehy[3:0]) begin
            n_bad++;
            $display("FAIL %s_hit: got (%0d,%0d) want (%0d,%0d)",
                     name, resp_hit_x, resp_hit_y, ehx, ehy);
        end
`endif
        @(negedge clk);
        n_cmp++;
        if (n_q - q0 != cnt || qx_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_qcount: got %0d want %0d", name, n_q - q0, cnt);
        end
        if (want_q > 0) begin
            n_cmp++;
            if (n_q - q0 != want_q) begin
                n_bad++;
                $display("FAIL %s_qfixed: got %0d want %0d", name, n_q - q0, want_q);
            end
        end
        qx_q.delete();
        qy_q.delete();
    endtask

    task automatic test_empty_diag();
        clear_grid();
        lat = 1;
        test_segment("diag", 0, 0, 15, 15, 16);
    endtask

    task automatic test_early_hit();
        clear_grid();
        occ[5][2] = 1;
        lat = 2;
        test_segment("early_hit", 0, 0, 10, 4, 6);
        n_cmp++;
        if (last_qx != 5 || last_qy != 2) begin
            n_bad++;
            $display("FAIL early_hit_last: got (%0d,%0d) want (5,2)", last_qx, last_qy);
        end
    endtask

    task automatic test_single();
        clear_grid();
        lat = 1;
        test_segment("single_free", 7, 3, 7, 3, 1);
        occ[7][3] = 1;
        test_segment("single_occ", 7, 3, 7, 3, 1);
    endtask

    task automatic test_stall();
        int  cnt, q0;
        bit  to, ec;
        int  ehx, ehy;
        clear_grid();
        lat = 3;
        model_push(12, 9, 2, 9, cnt);
        q0 = n_q;
        grid_ready_for_input = 1'b0;
        send_req(12, 9, 2, 9);
        repeat (5) @(negedge clk);
        grid_ready_for_input = 1'b1;
        wait_resp(to);
        ec  = coll_q.pop_front();
        ehx = hx_q.pop_front();
        ehy = hy_q.pop_front();
        n_cmp++;
        if (to || resp_collision !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_resp: got to=%b coll=%b want to=0 coll=%b",
                     to, resp_collision, ec);
        end
        @(negedge clk);
        n_cmp++;
        if (n_q - q0 != 11 || qx_q.size() != 0) begin
            n_bad++;
            $display("FAIL stall_qcount: got %0d want 11", n_q - q0);
        end
    endtask

    task automatic test_backpressure();
        int  cnt;
        bit  to, ec;
        int  ehx, ehy;
        clear_grid();
        occ[5][5] = 1;
        lat = 1;
        model_push(3, 3, 6, 6, cnt);
        resp_ready = 1'b0;
        send_req(3, 3, 6, 6);
        wait_resp(to);
        ec  = coll_q.pop_front();
        ehx = hx_q.pop_front();
        ehy = hy_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (to || resp_valid !== 1'b1 || resp_collision !== ec || req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold%0d: got rv=%b coll=%b rr=%b want 1 %b 0",
                         i, resp_valid, resp_collision, req_ready, ec);
            end
`ifdef SEGMENT_CHECK_HIT_REPORT_EN
            n_cmp++;
            if (resp_hit_x !== ehx[3:0] || resp_hit_y !== ehy[3:0]) begin
                n_bad++;
                $display("FAIL bp_hit%0d: got (%0d,%0d) want (%0d,%0d)",
                         i, resp_hit_x, resp_hit_y, ehx, ehy);
            end
`endif
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || qx_q.size() != 0) begin
            n_bad++;
            $display("FAIL bp_release: got rv=%b rr=%b left=%0d want 0 1 0",
                     resp_valid, req_ready, qx_q.size());
        end
    endtask

    task automatic test_reset_midwalk();
        int  cnt, q0;
        bit  seen;
        clear_grid();
        lat = 4;
        model_push(0, 0, 9, 0, cnt);
        q0 = n_q;
        send_req(0, 0, 9, 0);
        for (int i = 0; i < 50 && n_q == q0; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        qx_q.delete();
        qy_q.delete();
        coll_q.delete();
        hx_q.delete();
        hy_q.delete();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid || grid_input_valid || !req_ready) seen = 1;
        end
        n_cmp++;
        if (seen || n_q != q0 + 1) begin
            n_bad++;
            $display("FAIL rst_midwalk: got stray=%b queries=%0d want stray=0 queries=1",
                     seen, n_q - q0);
        end
        lat = 1;
        occ[4][4] = 1;
        test_segment("after_rst", 1, 1, 6, 6, 4);
    endtask

    task automatic test_back_to_back();
        int sx, sy, ex, ey;
        for (int t = 0; t < 12; t++) begin
            clear_grid();
            for (int k = 0; k < 6; k++)
                occ[$urandom_range(0, 15)][$urandom_range(0, 15)] = 1;
            lat = $urandom_range(1, 5);
            sx = $urandom_range(0, 15);
            sy = $urandom_range(0, 15);
            ex = $urandom_range(0, 15);
            ey = $urandom_range(0, 15);
            test_segment("b2b", sx, sy, ex, ey, 0);
        end
    endtask

    initial begin
        rst                  = 1'b1;
        req_valid            = 1'b0;
        resp_ready           = 1'b1;
        grid_ready_for_input = 1'b1;
        grid_output_valid    = 1'b0;
        grid_read_occupied   = 1'b0;
        start_x = 0; start_y = 0; end_x = 0; end_y = 0;
        test_reset();
        test_empty_diag();
        test_early_hit();
        test_single();
        test_stall();
        test_backpressure();
        test_reset_midwalk();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
